// File: rtl/bram_index_reader.sv
// bram_index_reader
// Buffers bin indices from the address generator (no backpressure), clamps
// out-of-range or overflowed indices, reads a synchronous BRAM with fixed
// latency and returns the words on a valid/ready stream in order.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   index_in/_valid_in         bin index stream (always accepted or dropped)
//   index_overflow_in          converter overflow flag, qualified by valid
//   bram_en_out/_addr_out      BRAM read port (driven from registers only)
//   bram_rdata_in              BRAM data, READ_LATENCY cycles after enable
//   data_out/_clamped_out      result word and its clamp flag
//   data_valid_out/_ready_in   result handshake
//   drop_error_out             sticky: index arrived while index FIFO full
//
// Build option: define BRAM_INDEX_READER_SIGNED_EN to treat index_in as two's
// complement (negative indices clamp to address 0).
module bram_index_reader #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned MEM_DEPTH      = 1024,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned IDX_FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] index_in,
  input  logic                  index_valid_in,
  input  logic                  index_overflow_in,
  output logic                  bram_en_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  input  logic [DATA_WIDTH-1:0] bram_rdata_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_clamped_out,
  output logic                  data_valid_out,
  input  logic                  data_ready_in,
  output logic                  drop_error_out
);

  localparam int unsigned RESULT_DEPTH = READ_LATENCY + 2;
  localparam int unsigned IF_PTR_W     = $clog2(IDX_FIFO_DEPTH);
  localparam int unsigned IF_CNT_W     = IF_PTR_W + 1;
  localparam int unsigned RB_PTR_W     = $clog2(RESULT_DEPTH);
  localparam int unsigned RB_CNT_W     = $clog2(RESULT_DEPTH + 1);
  localparam int unsigned ENTRY_W      = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX    = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [DATA_WIDTH:0]   DEPTH_LIMIT = (DATA_WIDTH + 1)'(MEM_DEPTH);

  // Clamp incoming index to a legal BRAM address
  logic [ADDR_WIDTH-1:0] clamp_addr;
  logic                  clamp_flag;

  always_comb begin
    clamp_addr = index_in[ADDR_WIDTH-1:0];
    clamp_flag = 1'b0;
`ifdef BRAM_INDEX_READER_SIGNED_EN
    if (index_overflow_in) begin
      clamp_addr = ADDR_MAX;
      clamp_flag = 1'b1;
    end else if (index_in[DATA_WIDTH-1]) begin
      clamp_addr = '0;
      clamp_flag = 1'b1;
    end else if ({1'b0, index_in} >= DEPTH_LIMIT) begin
      clamp_addr = ADDR_MAX;
      clamp_flag = 1'b1;
    end
`else
    if (index_overflow_in || ({1'b0, index_in} >= DEPTH_LIMIT)) begin
      clamp_addr = ADDR_MAX;
      clamp_flag = 1'b1;
    end
`endif
  end

  // Index FIFO: {clamp flag, address}
  logic [ENTRY_W-1:0]  if_mem [IDX_FIFO_DEPTH];
  logic [IF_PTR_W-1:0] if_wr_ptr, if_rd_ptr;
  logic [IF_CNT_W-1:0] if_count;
  logic [RB_CNT_W-1:0] credit;
  logic                if_empty, if_full, issue_c, if_push, pop_c;

  assign if_empty = (if_count == '0);
  assign if_full  = (if_count == IF_CNT_W'(IDX_FIFO_DEPTH));
  assign issue_c  = !if_empty && (credit < RB_CNT_W'(RESULT_DEPTH));
  // A full FIFO still accepts a write in the cycle it pops
  assign if_push  = index_valid_in && (!if_full || issue_c);
  assign pop_c    = data_valid_out && data_ready_in;

  always_ff @(posedge clk) begin
    if (if_push) if_mem[if_wr_ptr] <= {clamp_flag, clamp_addr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_wr_ptr      <= '0;
      if_rd_ptr      <= '0;
      if_count       <= '0;
      drop_error_out <= 1'b0;
    end else begin
      if (if_push) if_wr_ptr <= if_wr_ptr + IF_PTR_W'(1);
      if (issue_c) if_rd_ptr <= if_rd_ptr + IF_PTR_W'(1);
      case ({if_push, issue_c})
        2'b10:   if_count <= if_count + IF_CNT_W'(1);
        2'b01:   if_count <= if_count - IF_CNT_W'(1);
        default: if_count <= if_count;
      endcase
      if (index_valid_in && if_full && !issue_c) drop_error_out <= 1'b1;
    end
  end

  // Credits cover in-flight reads plus result-buffer occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credit <= '0;
    end else begin
      case ({issue_c, pop_c})
        2'b10:   credit <= credit + RB_CNT_W'(1);
        2'b01:   credit <= credit - RB_CNT_W'(1);
        default: credit <= credit;
      endcase
    end
  end

  assign bram_en_out   = issue_c;
  assign bram_addr_out = issue_c ? if_mem[if_rd_ptr][ADDR_WIDTH-1:0] : '0;

  // Tag returning BRAM data with valid and clamp flag
  logic [READ_LATENCY-1:0] rv_sr, rf_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rv_sr <= '0;
      rf_sr <= '0;
    end else begin
      rv_sr[0] <= issue_c;
      rf_sr[0] <= if_mem[if_rd_ptr][ADDR_WIDTH];
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        rv_sr[i] <= rv_sr[i-1];
        rf_sr[i] <= rf_sr[i-1];
      end
    end
  end

  // Result buffer; never overflows because issue is credit-limited
  logic [DATA_WIDTH-1:0] rb_data [RESULT_DEPTH];
  logic                  rb_flag [RESULT_DEPTH];
  logic [RB_PTR_W-1:0]   rb_wr_ptr, rb_rd_ptr;
  logic [RB_CNT_W-1:0]   rb_count;
  logic                  rb_push;

  assign rb_push = rv_sr[READ_LATENCY-1];

  function automatic logic [RB_PTR_W-1:0] rb_next(input logic [RB_PTR_W-1:0] p);
    return (p == RB_PTR_W'(RESULT_DEPTH - 1)) ? '0 : p + RB_PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rb_push) begin
      rb_data[rb_wr_ptr] <= bram_rdata_in;
      rb_flag[rb_wr_ptr] <= rf_sr[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_wr_ptr <= '0;
      rb_rd_ptr <= '0;
      rb_count  <= '0;
    end else begin
      if (rb_push) rb_wr_ptr <= rb_next(rb_wr_ptr);
      if (pop_c)   rb_rd_ptr <= rb_next(rb_rd_ptr);
      case ({rb_push, pop_c})
        2'b10:   rb_count <= rb_count + RB_CNT_W'(1);
        2'b01:   rb_count <= rb_count - RB_CNT_W'(1);
        default: rb_count <= rb_count;
      endcase
    end
  end

  assign data_valid_out   = (rb_count != '0);
  assign data_out         = data_valid_out ? rb_data[rb_rd_ptr] : '0;
  assign data_clamped_out = data_valid_out ? rb_flag[rb_rd_ptr] : 1'b0;

endmodule

// File: tb/tb_bram_index_reader.sv
// Directed self-checking bench for bram_index_reader (default parameters,
// BRAM modelled with one cycle of read latency).
module tb_bram_index_reader;

  logic        clk;
  logic        reset;
  logic [15:0] index_in;
  logic        index_valid_in;
  logic        index_overflow_in;
  logic        bram_en_out;
  logic [9:0]  bram_addr_out;
  logic [15:0] bram_rdata_in;
  logic [15:0] data_out;
  logic        data_clamped_out;
  logic        data_valid_out;
  logic        data_ready_in;
  logic        drop_error_out;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] bram [1024];
  int          exp_addr [100];

  bram_index_reader dut (
    .clk               (clk),
    .reset             (reset),
    .index_in          (index_in),
    .index_valid_in    (index_valid_in),
    .index_overflow_in (index_overflow_in),
    .bram_en_out       (bram_en_out),
    .bram_addr_out     (bram_addr_out),
    .bram_rdata_in     (bram_rdata_in),
    .data_out          (data_out),
    .data_clamped_out  (data_clamped_out),
    .data_valid_out    (data_valid_out),
    .data_ready_in     (data_ready_in),
    .drop_error_out    (drop_error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous BRAM, one cycle read latency
  always @(posedge clk) begin
    if (bram_en_out) bram_rdata_in <= bram[bram_addr_out];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One isolated index with ready high: enable one cycle later, data two after that
  task automatic send_one(input logic [15:0] idx, input logic ovf,
                          input logic [9:0] addr, input logic flag);
    index_in          = idx;
    index_valid_in    = 1'b1;
    index_overflow_in = ovf;
    data_ready_in     = 1'b1;
    tick();
    index_valid_in    = 1'b0;
    index_overflow_in = 1'b0;
    check("issue_en", 32'(bram_en_out), 32'd1);
    check("issue_addr", 32'(bram_addr_out), 32'(addr));
    check("early_valid", 32'(data_valid_out), 32'd0);
    tick();
    check("lat_valid", 32'(data_valid_out), 32'd0);
    tick();
    check("out_valid", 32'(data_valid_out), 32'd1);
    check("out_data", 32'(data_out), 32'(bram[addr]));
    check("out_flag", 32'(data_clamped_out), 32'(flag));
    tick();
    check("out_drained", 32'(data_valid_out), 32'd0);
  endtask

  initial begin
    int en_cnt;
    int k;
    int first_cyc;
    int last_cyc;
    int stray;

    for (int i = 0; i < 1024; i++) bram[i] = 16'(i * 7 + 16'h1000);
    bram[5] = 16'h1234;
    for (int i = 0; i < 100; i++) exp_addr[i] = (i * 37 + 3) % 1024;

    reset             = 1'b1;
    index_in          = '0;
    index_valid_in    = 1'b0;
    index_overflow_in = 1'b0;
    data_ready_in     = 1'b1;
    bram_rdata_in     = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_en", 32'(bram_en_out), 32'd0);
    check("rst_addr", 32'(bram_addr_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_flag", 32'(data_clamped_out), 32'd0);
    check("rst_valid", 32'(data_valid_out), 32'd0);
    check("rst_drop", 32'(drop_error_out), 32'd0);
    reset = 1'b0;
    tick();

    // Basic read and clamp boundaries
    send_one(16'd5, 1'b0, 10'd5, 1'b0);
    send_one(16'd2000, 1'b0, 10'd1023, 1'b1);
    send_one(16'd7, 1'b1, 10'd1023, 1'b1);
    send_one(16'd1023, 1'b0, 10'd1023, 1'b0);
    send_one(16'd1024, 1'b0, 10'd1023, 1'b1);
`ifdef BRAM_INDEX_READER_SIGNED_EN
    send_one(16'hFFFE, 1'b0, 10'd0, 1'b1);
`else
    send_one(16'hFFFE, 1'b0, 10'd1023, 1'b1);
`endif

    // 20 indices with downstream stalled: 3 reads, 8 buffered, 9 dropped
    data_ready_in = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      index_in       = 16'(100 + i);
      index_valid_in = 1'b1;
      tick();
      if (bram_en_out) en_cnt++;
    end
    index_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bram_en_out) en_cnt++;
    end
    check("stall_reads", 32'(en_cnt), 32'd3);
    check("stall_drop", 32'(drop_error_out), 32'd1);
    check("stall_valid", 32'(data_valid_out), 32'd1);
    check("stall_head", 32'(data_out), 32'(bram[100]));
    tick();
    tick();
    check("stall_hold", 32'(data_out), 32'(bram[100]));
    data_ready_in = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (data_valid_out) begin
        check("stall_word", 32'(data_out), 32'(bram[100 + k]));
        k++;
      end
      tick();
    end
    check("stall_count", 32'(k), 32'd11);
    check("drop_sticky", 32'(drop_error_out), 32'd1);

    // Reset clears the sticky drop flag
    reset = 1'b1;
    #1;
    check("drop_clr", 32'(drop_error_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 100 back-to-back indices, ready high: one output per cycle, in order
    k = 0;
    first_cyc = -1;
    last_cyc = -1;
    for (int cyc = 0; cyc < 130; cyc++) begin
      if (data_valid_out && k < 100) begin
        check("stream_word", 32'(data_out), 32'(bram[exp_addr[k]]));
        if (k == 0) first_cyc = cyc;
        last_cyc = cyc;
        k++;
      end
      if (cyc < 100) begin
        index_in       = 16'(exp_addr[cyc]);
        index_valid_in = 1'b1;
      end else begin
        index_valid_in = 1'b0;
      end
      tick();
    end
    check("stream_count", 32'(k), 32'd100);
    check("stream_first", 32'(first_cyc), 32'd3);
    check("stream_span", 32'(last_cyc - first_cyc), 32'd99);
    check("stream_drop", 32'(drop_error_out), 32'd0);

    // Reset with reads in flight
    for (int i = 0; i < 4; i++) begin
      index_in       = 16'(200 + i);
      index_valid_in = 1'b1;
      tick();
    end
    index_valid_in = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_en", 32'(bram_en_out), 32'd0);
    check("mid_addr", 32'(bram_addr_out), 32'd0);
    check("mid_data", 32'(data_out), 32'd0);
    check("mid_flag", 32'(data_clamped_out), 32'd0);
    check("mid_valid", 32'(data_valid_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (data_valid_out || bram_en_out) stray++;
    end
    check("post_rst_idle", 32'(stray), 32'd0);
    send_one(16'd9, 1'b0, 10'd9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
